// File: rtl/ball_link_scheduler.sv
// Sequences ball/lose frames to the opponent board as single-byte I2C register
// writes, with a gap between bytes, whole-frame retry on NACK/timeout, and abort.
module ball_link_scheduler #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h42,
  parameter int         MAX_RETRY      = 3,
  parameter int         GAP_CYCLES     = 250,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       send_req,
  input  logic       lose_req,
  input  logic       abort,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_cnt,
  input  logic       fast_speed,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_reg,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_done,
  input  logic       i2c_ack_err,
  output logic       xfer_done,
  output logic       xfer_fail,
  output logic       busy,
  output logic [1:0] retry_cnt
);

  localparam int CNT_MIN = 17;
  localparam int CNT_REQ = ($clog2(TIMEOUT_CYCLES + 1) > $clog2(GAP_CYCLES + 1)) ?
                           $clog2(TIMEOUT_CYCLES + 1) : $clog2(GAP_CYCLES + 1);
  localparam int CNT_W   = (CNT_REQ > CNT_MIN) ? CNT_REQ : CNT_MIN;

  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT_DONE, GAP, DONE, FAIL} state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] gap_cnt;
  logic [2:0]       byte_idx;
  logic             snap_lose;
  logic [9:0]       snap_y;
  logic [7:0]       snap_vy;
  logic [1:0]       snap_grav;
  logic             snap_fast;

  logic [7:0] cur_reg;
  logic [7:0] cur_data;
  logic       last_byte;
  logic       timeout_hit;
  logic       gap_end;
  logic       can_retry;

  assign i2c_addr = SLAVE_ADDR;
  assign busy     = (state != IDLE);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cur_reg     = snap_lose ? 8'd5 : {5'b0, byte_idx};
    cur_data    = 8'h00;
    last_byte   = snap_lose || (byte_idx == 3'd5);
    timeout_hit = (timer == CNT_W'(TIMEOUT_CYCLES - 1));
    gap_end     = (gap_cnt == CNT_W'(GAP_CYCLES - 1));
    can_retry   = (int'(retry_cnt) < MAX_RETRY);
    if (snap_lose) begin
      cur_data = 8'h01;
    end else begin
      case (byte_idx)
        3'd0:    cur_data = {snap_y[9:8], 6'b0};
        3'd1:    cur_data = snap_y[7:0];
        3'd2:    cur_data = snap_vy;
        3'd3:    cur_data = {6'b0, snap_grav};
        3'd4:    cur_data = {7'b0, snap_fast};
        default: cur_data = 8'h00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      gap_cnt   <= '0;
      byte_idx  <= '0;
      snap_lose <= 1'b0;
      snap_y    <= '0;
      snap_vy   <= '0;
      snap_grav <= '0;
      snap_fast <= 1'b0;
      i2c_start <= 1'b0;
      i2c_reg   <= '0;
      i2c_wdata <= '0;
      xfer_done <= 1'b0;
      xfer_fail <= 1'b0;
      retry_cnt <= '0;
    end else begin
      i2c_start <= 1'b0;
      xfer_done <= 1'b0;
      xfer_fail <= 1'b0;
      if (abort) begin
        // Restart wins over everything, including a done arriving this same cycle.
        state     <= IDLE;
        retry_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (lose_req || send_req) begin
              state     <= LATCH;
              snap_lose <= lose_req;
              snap_y    <= ball_y;
              snap_vy   <= ball_vy;
              snap_grav <= gravity_cnt;
              snap_fast <= fast_speed;
              byte_idx  <= '0;
              retry_cnt <= '0;
            end
          end
          LATCH: begin
            state     <= ISSUE;
            i2c_start <= 1'b1;
            i2c_reg   <= cur_reg;
            i2c_wdata <= cur_data;
          end
          ISSUE: begin
            state <= WAIT_DONE;
            timer <= '0;
          end
          WAIT_DONE: begin
            if (i2c_done && !i2c_ack_err) begin
              if (last_byte) begin
                state     <= DONE;
                xfer_done <= 1'b1;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                state    <= GAP;
                gap_cnt  <= '0;
              end
            end else if (i2c_done || timeout_hit) begin
              if (can_retry) begin
                retry_cnt <= retry_cnt + 2'd1;
                byte_idx  <= '0;
                state     <= GAP;
                gap_cnt   <= '0;
              end else begin
                state     <= FAIL;
                xfer_fail <= 1'b1;
              end
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
          GAP: begin
            if (gap_end) begin
              state     <= ISSUE;
              i2c_start <= 1'b1;
              i2c_reg   <= cur_reg;
              i2c_wdata <= cur_data;
            end else begin
              gap_cnt <= gap_cnt + CNT_W'(1);
            end
          end
          DONE:    state <= IDLE;
          FAIL:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_link_scheduler.sv
// Scoreboard bench for ball_link_scheduler: expected writes/pulses are queued by the
// stimulus, a monitor pops and compares them, and an I2C responder model acks/NACKs.
module tb_ball_link_scheduler;

  localparam int         GAP  = 8;
  localparam int         TMO  = 200;
  localparam int         MAXR = 3;
  localparam logic [6:0] ADDR = 7'h42;

  logic       clk_25MHZ = 1'b0;
  logic       reset;
  logic       send_req, lose_req, abort;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_cnt;
  logic       fast_speed;
  logic       i2c_start;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_reg, i2c_wdata;
  logic       i2c_done, i2c_ack_err;
  logic       xfer_done, xfer_fail, busy;
  logic [1:0] retry_cnt;

  ball_link_scheduler #(
    .SLAVE_ADDR(ADDR), .MAX_RETRY(MAXR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_25MHZ(clk_25MHZ), .reset(reset), .send_req(send_req), .lose_req(lose_req),
    .abort(abort), .ball_y(ball_y), .ball_vy(ball_vy), .gravity_cnt(gravity_cnt),
    .fast_speed(fast_speed), .i2c_start(i2c_start), .i2c_addr(i2c_addr),
    .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata), .i2c_done(i2c_done),
    .i2c_ack_err(i2c_ack_err), .xfer_done(xfer_done), .xfer_fail(xfer_fail),
    .busy(busy), .retry_cnt(retry_cnt)
  );

  always #20 clk_25MHZ = ~clk_25MHZ;

  typedef enum int {EV_WRITE, EV_DONE, EV_FAIL} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] payload;
  } ev_t;

  ev_t exp_q[$];
  int  start_log[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  wr_total = 0;
  int  done_seen = 0;
  int  fail_seen = 0;
  int  nack_at = -1;
  int  abort_at = -1;
  bit  silent = 1'b0;

  always @(posedge clk_25MHZ) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input ev_kind_t k, input logic [15:0] p);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind=%0d payload=0x%h required none", k, p);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (k == EV_WRITE) check("write_reg_data", {16'h0, p}, {16'h0, e.payload});
    end
  endtask

  // Monitor: compares every DUT output event against the head of the expectation queue.
  initial forever begin
    @(negedge clk_25MHZ);
    if (!reset) begin
      if (i2c_start) begin
        start_log.push_back(cyc);
        check("i2c_addr", 32'(i2c_addr), 32'(ADDR));
        score(EV_WRITE, {i2c_reg, i2c_wdata});
      end
      if (xfer_done) begin
        done_seen++;
        score(EV_DONE, 16'h0);
      end
      if (xfer_fail) begin
        fail_seen++;
        score(EV_FAIL, 16'h0);
      end
    end
  end

  // Responder: completes each write two cycles after it is seen, NACKing or aborting on request.
  initial begin
    int idx;
    i2c_done = 1'b0;
    i2c_ack_err = 1'b0;
    abort = 1'b0;
    forever begin
      @(negedge clk_25MHZ);
      if (i2c_start) begin
        idx = wr_total;
        wr_total++;
        if (!silent) begin
          repeat (2) @(posedge clk_25MHZ);
          #1;
          i2c_done = 1'b1;
          i2c_ack_err = (idx == nack_at);
          abort = (idx == abort_at);
          @(posedge clk_25MHZ);
          #1;
          i2c_done = 1'b0;
          i2c_ack_err = 1'b0;
          abort = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_25MHZ);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_25MHZ);
    #1;
  endtask

  task automatic exp_write(input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back('{EV_WRITE, {r, d}});
  endtask

  task automatic exp_evt(input ev_kind_t k);
    exp_q.push_back('{k, 16'h0});
  endtask

  task automatic set_ball(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                          input logic f);
    ball_y = y;
    ball_vy = vy;
    gravity_cnt = g;
    fast_speed = f;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      sample();
      n++;
    end
    check({name, "_complete"}, 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int n = 0;
    while (start_log.size() < target && n < budget) begin
      sample();
      n++;
    end
    check({name, "_reached"}, 32'(start_log.size() >= target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int d0;
    reset = 1'b1;
    send_req = 1'b0;
    lose_req = 1'b0;
    set_ball(10'h0, 8'h0, 2'h0, 1'b0);
    repeat (3) tick();

    // Reset state
    check("reset_outputs_zero",
          {11'h0, busy, i2c_start, xfer_done, xfer_fail, retry_cnt, i2c_reg, i2c_wdata}, 0);
    check("reset_addr", 32'(i2c_addr), 32'h42);
    reset = 1'b0;
    tick();

    // Ball frame: ball_y[9:8]=2'b10 puts 0x80 in reg 0, vy=-3 is 0xFD
    set_ball(10'h2C5, 8'hFD, 2'd2, 1'b1);
    exp_write(8'd0, 8'h80); exp_write(8'd1, 8'hC5); exp_write(8'd2, 8'hFD);
    exp_write(8'd3, 8'h02); exp_write(8'd4, 8'h01); exp_write(8'd5, 8'h00);
    exp_evt(EV_DONE);
    send_req = 1'b1;
    tick();
    check("latch_no_start", 32'(i2c_start), 0);
    check("busy_after_req", 32'(busy), 1);
    send_req = 1'b0;
    tick();
    check("first_start_latency", 32'(i2c_start), 1);
    set_ball(10'h3FF, 8'h00, 2'd0, 1'b0);  // late changes must not reach the frame
    wait_quiet("ball_frame", 400);

    // Lose has priority over send in the same cycle
    exp_write(8'd5, 8'h01);
    exp_evt(EV_DONE);
    send_req = 1'b1;
    lose_req = 1'b1;
    tick();
    send_req = 1'b0;
    lose_req = 1'b0;
    wait_quiet("lose_priority", 200);

    // NACK on byte 3 restarts the frame from reg 0 after the gap
    set_ball(10'h155, 8'h7F, 2'd1, 1'b0);
    exp_write(8'd0, 8'h40); exp_write(8'd1, 8'h55); exp_write(8'd2, 8'h7F);
    exp_write(8'd3, 8'h01);
    exp_write(8'd0, 8'h40); exp_write(8'd1, 8'h55); exp_write(8'd2, 8'h7F);
    exp_write(8'd3, 8'h01); exp_write(8'd4, 8'h00); exp_write(8'd5, 8'h00);
    exp_evt(EV_DONE);
    base = start_log.size();
    nack_at = wr_total + 3;
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    wait_starts("nack_restart", base + 5, 400);
    check("nack_retry_cnt", 32'(retry_cnt), 1);
    check("nack_restart_spacing", start_log[base+4] - start_log[base+3], GAP + 3);
    wait_quiet("nack_frame", 400);
    nack_at = -1;

    // Held request gives back-to-back frames, each with its own snapshot
    set_ball(10'h3C5, 8'hFD, 2'd2, 1'b1);
    exp_write(8'd0, 8'hC0); exp_write(8'd1, 8'hC5); exp_write(8'd2, 8'hFD);
    exp_write(8'd3, 8'h02); exp_write(8'd4, 8'h01); exp_write(8'd5, 8'h00);
    exp_evt(EV_DONE);
    exp_write(8'd0, 8'h80); exp_write(8'd1, 8'h01); exp_write(8'd2, 8'h80);
    exp_write(8'd3, 8'h03); exp_write(8'd4, 8'h00); exp_write(8'd5, 8'h00);
    exp_evt(EV_DONE);
    send_req = 1'b1;
    tick();
    check("new_frame_clears_retry", 32'(retry_cnt), 0);
    d0 = done_seen;
    n = 0;
    while (done_seen == d0 && n < 400) begin
      sample();
      n++;
    end
    check("b2b_first_done", 32'(done_seen != d0), 1);
    tick();
    set_ball(10'h201, 8'h80, 2'd3, 1'b0);
    tick();
    send_req = 1'b0;
    wait_quiet("back_to_back", 400);

    // Abort together with i2c_done on byte 2 of a retried frame
    set_ball(10'h2C5, 8'hFD, 2'd2, 1'b1);
    exp_write(8'd0, 8'h80);
    exp_write(8'd0, 8'h80); exp_write(8'd1, 8'hC5); exp_write(8'd2, 8'hFD);
    nack_at = wr_total;
    abort_at = wr_total + 3;
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    n = 0;
    while (!abort && n < 400) begin
      sample();
      n++;
    end
    check("abort_reached", 32'(abort), 1);
    check("retry_before_abort", 32'(retry_cnt), 1);
    tick();
    check("abort_idle", {30'h0, busy, xfer_done}, 0);
    check("abort_retry_clear", 32'(retry_cnt), 0);
    repeat (3 * GAP) tick();
    wait_quiet("abort", 50);
    nack_at = -1;
    abort_at = -1;

    // Retry exhaustion: responder never completes; four attempts then fail
    silent = 1'b1;
    for (int i = 0; i < MAXR + 1; i++) exp_write(8'd5, 8'h01);
    exp_evt(EV_FAIL);
    base = start_log.size();
    d0 = fail_seen;
    lose_req = 1'b1;
    tick();
    lose_req = 1'b0;
    wait_starts("exhaust_attempts", base + 4, 1500);
    check("timeout_retry_spacing", start_log[base+1] - start_log[base], TMO + GAP + 1);
    n = 0;
    while (fail_seen == d0 && n < 400) begin
      sample();
      n++;
    end
    check("exhaust_fail_seen", 32'(fail_seen != d0), 1);
    check("exhaust_retry_cnt", 32'(retry_cnt), 3);
    tick();
    check("exhaust_not_busy", 32'(busy), 0);
    wait_quiet("exhaust", 50);
    silent = 1'b0;

    // Reset asserted in the gap after reg 1
    set_ball(10'h2C5, 8'hFD, 2'd2, 1'b1);
    exp_write(8'd0, 8'h80); exp_write(8'd1, 8'hC5);
    base = start_log.size();
    d0 = done_seen;
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    wait_starts("reset_gap_writes", base + 2, 400);
    repeat (4) tick();
    check("pre_reset_busy", {23'h0, busy, i2c_reg}, {23'h0, 1'b1, 8'd1});
    #5;
    reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {11'h0, busy, i2c_start, xfer_done, xfer_fail, retry_cnt, i2c_reg, i2c_wdata}, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3 * GAP) tick();
    check("no_start_after_reset", start_log.size() - base, 2);
    check("no_done_after_reset", done_seen - d0, 0);
    wait_quiet("reset_mid_frame", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
